// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares the single LC-3b memory port between instruction fetch and data access.
// Ties are broken round-robin, and the winning request is latched for the whole memory transaction.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INST = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  last_grant_r;
  logic                  op_write_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [MASK_WIDTH-1:0] mask_r;
  logic                  i_req_s;
  logic                  d_req_s;
  logic                  grant_inst_s;
  logic                  grant_data_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

  // Grant decision, only meaningful while idle; a tie goes to the port that did not win last.
  always_comb begin
    grant_inst_s = 1'b0;
    grant_data_s = 1'b0;
    if (state_r == S_IDLE) begin
      if (i_req_s && d_req_s) begin
        if (last_grant_r == GRANT_DATA) begin
          grant_inst_s = 1'b1;
        end else begin
          grant_data_s = 1'b1;
        end
      end else if (i_req_s) begin
        grant_inst_s = 1'b1;
      end else if (d_req_s) begin
        grant_data_s = 1'b1;
      end else begin
        grant_inst_s = 1'b0;
        grant_data_s = 1'b0;
      end
    end else begin
      grant_inst_s = 1'b0;
      grant_data_s = 1'b0;
    end
  end

  // Next-state logic: every transaction returns through idle, so back-to-back grants see one idle cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (grant_inst_s) begin
          state_nxt_s = S_INST;
        end else if (grant_data_s) begin
          state_nxt_s = S_DATA;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_INST, S_DATA: begin
        if (mem_resp) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, round-robin history and the latched request operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      last_grant_r <= GRANT_DATA;
      op_write_r   <= 1'b0;
      addr_r       <= {ADDR_WIDTH{1'b0}};
      wdata_r      <= {DATA_WIDTH{1'b0}};
      mask_r       <= {MASK_WIDTH{1'b1}};
    end else begin
      state_r <= state_nxt_s;
      if (grant_inst_s) begin
        last_grant_r <= GRANT_INST;
        op_write_r   <= 1'b0;
        addr_r       <= i_address;
        wdata_r      <= {DATA_WIDTH{1'b0}};
        mask_r       <= {MASK_WIDTH{1'b1}};
      end else if (grant_data_s) begin
        // Read and write together is illegal from the requester; the write wins.
        last_grant_r <= GRANT_DATA;
        op_write_r   <= d_write;
        addr_r       <= d_address;
        wdata_r      <= d_wdata;
        mask_r       <= d_wmask;
      end
    end
  end

  assign mem_read        = (state_r == S_INST) || ((state_r == S_DATA) && !op_write_r);
  assign mem_write       = (state_r == S_DATA) && op_write_r;
  assign mem_byte_enable = (state_r == S_IDLE) ? {MASK_WIDTH{1'b1}} : mask_r;
  assign mem_address     = addr_r;
  assign mem_wdata       = wdata_r;

  assign i_resp  = (state_r == S_INST) && mem_resp;
  assign d_resp  = (state_r == S_DATA) && mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic against a memory model,
// with a per-port response scoreboard and a cycle-level arbitration reference.
module tb_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [15:0] rd;
  } dexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [1:0]  d_wmask;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  logic        mem_resp_auto;
  logic        force_resp;
  logic        mem_auto;
  int          fixed_lat;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_arr [0:511];
  logic [15:0] ref_arr [0:511];
  logic [15:0] i_q [$];
  dexp_t       d_q [$];

  always #5 clk = ~clk;

  assign mem_resp = mem_auto ? mem_resp_auto : force_resp;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Instruction addresses live at 0x30xx and data addresses at 0x40xx; bit 14 tells them apart.
  function automatic logic [8:0] idx(input logic [15:0] a);
    return {a[14], a[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_inst(input logic [15:0] a, output int n);
    i_q.push_back(ref_arr[idx(a)]);
    i_read = 1'b1;
    i_address = a;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (i_resp) break;
    end
    chk("inst_done", i_resp, 1);
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic do_data(input logic wr, input logic both, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] m, output int n);
    dexp_t       e;
    logic [15:0] w;
    e.wr = wr;
    e.rd = 16'h0000;
    if (wr) begin
      w = ref_arr[idx(a)];
      if (m[0]) w[7:0]  = wd[7:0];
      if (m[1]) w[15:8] = wd[15:8];
      ref_arr[idx(a)] = w;
    end else begin
      e.rd = ref_arr[idx(a)];
    end
    d_q.push_back(e);
    d_read = !wr || both;
    d_write = wr;
    d_address = a;
    d_wdata = wd;
    d_wmask = m;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (d_resp) break;
    end
    chk("data_done", d_resp, 1);
    @(posedge clk); #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  // Response scoreboard: each port's responses must come back in issue order with the modelled data.
  initial begin
    logic [15:0] ie;
    dexp_t       de;
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) chk("resp_exclusive", {i_resp, d_resp} == 2'b11, 0);
      if (i_resp) begin
        if (i_q.size() == 0) chk("i_resp_unexpected", i_resp, 0);
        else begin
          ie = i_q.pop_front();
          chk("i_rdata", i_rdata, ie);
        end
      end
      if (d_resp) begin
        if (d_q.size() == 0) chk("d_resp_unexpected", d_resp, 0);
        else begin
          de = d_q.pop_front();
          if (!de.wr) chk("d_rdata", d_rdata, de.rd);
        end
      end
    end
  end

  // Memory model: answers a strobe after a fixed or random number of extra cycles and applies masked writes.
  initial begin
    bit          busy;
    int          wcnt;
    logic [15:0] w;
    busy = 1'b0;
    wcnt = 0;
    mem_resp_auto = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (!mem_auto) begin
        busy = 1'b0;
        mem_resp_auto = 1'b0;
      end else if (mem_resp_auto) begin
        busy = 1'b0;
        mem_resp_auto = 1'b0;
      end else if (mem_read || mem_write) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else begin
          wcnt--;
        end
        if (wcnt <= 0) begin
          w = mem_arr[idx(mem_address)];
          if (mem_write) begin
            if (mem_byte_enable[0]) w[7:0]  = mem_wdata[7:0];
            if (mem_byte_enable[1]) w[15:8] = mem_wdata[15:8];
            mem_arr[idx(mem_address)] = w;
          end
          mem_rdata = w;
          mem_resp_auto = 1'b1;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Arbitration reference: from the requests seen in an idle cycle, predict who owns the bus next cycle.
  initial begin
    logic i_pend, d_pend, rst_s, resp_s, strobe_prev, port_prev, last_port, armed;
    logic strobe_now, exp_port;
    armed = 1'b0;
    last_port = 1'b1;
    forever begin
      @(negedge clk);
      i_pend      = i_read;
      d_pend      = d_read | d_write;
      rst_s       = rst;
      resp_s      = mem_resp;
      strobe_prev = mem_read | mem_write;
      port_prev   = mem_address[14];
      @(posedge clk); #1;
      strobe_now = mem_read | mem_write;
      if (rst_s) begin
        armed = 1'b1;
        last_port = 1'b1;
        chk("rst_no_strobe", strobe_now, 0);
      end else if (!armed) begin
        armed = 1'b0;
      end else if (strobe_prev && resp_s) begin
        chk("idle_between", strobe_now, 0);
      end else if (strobe_prev) begin
        chk("hold_grant", {strobe_now, mem_address[14]}, {1'b1, port_prev});
      end else begin
        chk("grant_start", strobe_now, i_pend || d_pend);
        if (i_pend || d_pend) begin
          exp_port = (i_pend && d_pend) ? ~last_port : d_pend;
          chk("grant_port", mem_address[14], exp_port);
          if (!exp_port) chk("inst_is_read", {mem_read, mem_write}, 2'b10);
          last_port = exp_port;
        end
      end
    end
  end

  initial begin
    int n, nd;
    rst = 1'b1;
    i_read = 1'b0; i_address = 16'h0000;
    d_read = 1'b0; d_write = 1'b0; d_wmask = 2'b00; d_address = 16'h0000; d_wdata = 16'h0000;
    mem_auto = 1'b0; force_resp = 1'b0; fixed_lat = -1;
    for (int k = 0; k < 512; k++) begin
      mem_arr[k] = 16'(k * 40503 + 7);
      ref_arr[k] = 16'(k * 40503 + 7);
    end

    // Reset held two cycles, then idle with a stray mem_resp.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    chk("rst_be", mem_byte_enable, 2'b11);
    chk("rst_addr_wdata", {mem_address, mem_wdata}, 32'h0);
    @(posedge clk); #1 force_resp = 1'b1;
    @(negedge clk);
    chk("idle_resp_ignored", {i_resp, d_resp, mem_read, mem_write}, 4'b0000);
    @(posedge clk); #1 force_resp = 1'b0;
    mem_auto = 1'b1;

    // Single fetch, memory answers two cycles after the strobe rises.
    fixed_lat = 2;
    mem_arr[idx(16'h3000)] = 16'h1234;
    ref_arr[idx(16'h3000)] = 16'h1234;
    fork
      do_inst(16'h3000, n);
      begin
        @(negedge clk); chk("fetch_c0_quiet", mem_read, 0);
        @(negedge clk); chk("fetch_c1", {mem_read, mem_address}, {1'b1, 16'h3000});
      end
    join
    chk("fetch_latency", n, 4);

    // Masked data write, then read back the merged word.
    fixed_lat = 1;
    fork
      do_data(1'b1, 1'b0, 16'h4000, 16'hABCD, 2'b01, n);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("wr_strobes", {mem_write, mem_read, mem_byte_enable}, 4'b1001);
        chk("wr_bus", {mem_wdata, mem_address}, {16'hABCD, 16'h4000});
      end
    join
    chk("wr_latency", n, 3);
    do_data(1'b0, 1'b0, 16'h4000, 16'h0000, 2'b00, n);

    // Simultaneous requests straight after reset: instruction must win the first tie.
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fixed_lat = -1;
    fork
      do_inst(16'h3002, n);
      do_data(1'b0, 1'b0, 16'h4002, 16'h0000, 2'b00, nd);
    join
    chk("tie_inst_first", n < nd, 1);

    // Operand stability: requester address changes mid-transaction.
    fixed_lat = 3;
    fork
      do_data(1'b0, 1'b0, 16'h4000, 16'h0000, 2'b00, n);
      begin
        @(posedge clk); #1 d_address = 16'h5000;
        repeat (3) begin
          @(negedge clk);
          chk("addr_stable", mem_address, 16'h4000);
        end
      end
    join

    // Reset in the middle of a data write; the late mem_resp must not reach the requester.
    mem_auto = 1'b0;
    d_write = 1'b1; d_address = 16'h4004; d_wdata = 16'hBEEF; d_wmask = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_write", mem_write, 1);
    @(posedge clk); #1 rst = 1'b1; d_write = 1'b0;
    @(posedge clk); #1 rst = 1'b0; force_resp = 1'b1;
    @(negedge clk);
    chk("rst_mid_drop", {mem_write, mem_read, d_resp, i_resp}, 4'b0000);
    @(posedge clk); #1 force_resp = 1'b0;
    mem_auto = 1'b1;
    fixed_lat = 0;
    do_inst(16'h3004, n);
    chk("post_rst_fetch_lat", n, 2);

    // Random two-port traffic with random memory latency.
    fixed_lat = -1;
    fork
      begin
        int ni;
        for (int k = 0; k < 30; k++) begin
          do_inst(16'h3000 | 16'($urandom_range(0, 255)), ni);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        int nr;
        logic wr;
        for (int k = 0; k < 30; k++) begin
          wr = 1'($urandom_range(0, 1));
          do_data(wr, wr && ($urandom_range(0, 3) == 0), 16'h4000 | 16'($urandom_range(0, 15)),
                  16'($urandom), 2'($urandom_range(0, 3)), nr);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join
    for (int k = 0; k < 16; k++) begin
      do_data(1'b0, 1'b0, 16'h4000 | 16'(k), 16'h0000, 2'b00, n);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", i_q.size() + d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single LC-3b physical memory port between the instruction-fetch requester and the data (load/store) requester. It sits between the control/datapath pair and memory, so fetch and MDR traffic never drive the memory bus at the same time. Each requester sees a private request/response handshake. The arbiter serialises requests with round-robin tie-breaking and latches the granted request for the full memory transaction.

## Interface
Parameters:
- ADDR_WIDTH, 16, address width in bits
- DATA_WIDTH, 16, data width in bits; byte mask width is DATA_WIDTH/8

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_read  in  1  instruction-port read request
- i_address  in  ADDR_WIDTH  instruction-port address
- i_rdata  out  DATA_WIDTH  instruction-port read data
- i_resp  out  1  instruction-port completion pulse
- d_read  in  1  data-port read request
- d_write  in  1  data-port write request
- d_wmask  in  DATA_WIDTH/8  data-port byte-enable for writes
- d_address  in  ADDR_WIDTH  data-port address
- d_wdata  in  DATA_WIDTH  data-port write data
- d_rdata  out  DATA_WIDTH  data-port read data
- d_resp  out  1  data-port completion pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_byte_enable  out  DATA_WIDTH/8  memory byte mask
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_resp  in  1  memory completion

## Operation
- States:
  - s_idle: no memory strobe.
  - s_inst: instruction transaction outstanding.
  - s_data: data transaction outstanding.
- Requester protocol:
  - A requester holds its request and operands stable until its resp pulse.
  - It deasserts or issues a new request no earlier than the cycle after resp.
- s_idle grant decision (registered, takes effect next edge):
  - Only i_read asserted: go to s_inst.
  - Only d_read or d_write asserted: go to s_data.
  - Both ports requesting: grant the port not in last_grant (round-robin).
  - No request: stay in s_idle.
- On the grant edge, latch the following registers from the winning port:
  - op
  - address
  - wdata
  - mask
- The instruction port always latches op=read and mask all-ones.
- d_read and d_write both asserted is a protocol violation; treat it as a write.
- Update last_grant on the grant edge.
- Grant states:
  - mem_read or mem_write, mem_address, mem_wdata and mem_byte_enable are driven only from the latched registers. Requester input changes mid-transaction have no effect.
  - When mem_resp=1, pulse the granted port's resp for that same cycle and return to s_idle on the next edge.
  - The non-granted port's resp stays 0.
  - A pending request from the other port waits in s_idle for arbitration.
- Read data: mem_rdata passes combinationally to both i_rdata and d_rdata. The value is valid only when the matching resp=1.
- Idle outputs:
  - mem_read=0, mem_write=0
  - mem_byte_enable all-ones
  - mem_address and mem_wdata show the latched registers (don't-care to memory)
- A mem_resp seen in s_idle is ignored and produces no resp pulse.

## Timing
- Reset (rst=1 at an edge) sets:
  - state=s_idle
  - last_grant=data, so the first tie goes to instruction
  - latched address, wdata and op cleared to 0
  - latched mask all-ones
- Outputs after reset:
  - mem_read=0, mem_write=0
  - i_resp=0, d_resp=0
  - mem_byte_enable all-ones, mem_address=0, mem_wdata=0
- Reset mid-transaction:
  - Strobes drop in the cycle after the reset edge.
  - A mem_resp in that cycle or later produces no resp pulse.
  - Nothing is retried.
- Latency, with the request asserted at cycle 0 in s_idle:
  - Memory strobe appears at cycle 1.
  - With mem_resp at cycle k≥1, port resp appears at cycle k.
  - Minimum request-to-resp latency is 1 cycle after the request cycle.
- Back-to-back transactions always have exactly one s_idle cycle between them. Sustained throughput is one transaction per (memory latency + 1) cycles.
- A new request arriving in the same cycle as the other port's resp is seen in the following s_idle cycle.
- Fairness: if both ports request continuously, grants strictly alternate. No port waits more than one full transaction.

## Test plan
- Reset then idle:
  - Hold rst 2 cycles, no requests, pulse mem_resp → mem_read=mem_write=0, i_resp=d_resp=0 throughout, mem_byte_enable=2'b11.
- Single fetch:
  - i_read=1, i_address=16'h3000, memory returns 16'h1234 with mem_resp two cycles after mem_read rises.
  - → mem_read=1 from cycle 1, mem_address=16'h3000.
  - → i_resp=1 for exactly one cycle with i_rdata=16'h1234; d_resp stays 0.
- Data write with mask:
  - d_write=1, d_address=16'h4000, d_wdata=16'hABCD, d_wmask=2'b01.
  - → mem_write=1, mem_byte_enable=2'b01, mem_wdata=16'hABCD until mem_resp, then d_resp pulse.
- Simultaneous requests after reset:
  - i_read and d_read asserted together and held.
  - → instruction granted first, data granted second.
  - → one s_idle cycle between the two transactions.
  - → i_resp and d_resp never both 1 in the same cycle.
- Operand stability:
  - Change d_address from 16'h4000 to 16'h5000 one cycle after the grant.
  - → mem_address stays 16'h4000 for the whole transaction.
- Reset mid-transaction:
  - Assert rst while in s_data with mem_write=1, then pulse mem_resp.
  - → mem_write=0 after the reset edge, no d_resp pulse.
  - → a subsequent i_read is served normally.
